// File: rtl/fsm_lee_ram.sv
// fsm_lee_ram: sequential reader for the one-hot addressed register RAM.
// Sweeps locations 0..N_LOC-1 and hands each byte to a downstream consumer
// over a valid/ready handshake, in index order.
// Optional build macro SKIP_ZERO_EN: zero bytes are skipped and never presented.
module fsm_lee_ram #(
    parameter int N_LOC  = 32,
    parameter int DATA_W = 8,
    parameter int IDX_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] ram_data_in,
    output logic [N_LOC-1:0]  dir_ram,
    output logic              r_ram_enable,
    output logic              w_ram_enable,
    output logic [DATA_W-1:0] out_data,
    output logic [IDX_W-1:0]  out_index,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        CAPT,
        PRES,
        FIN
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_LOC - 1);

    state_t            state_q;
    logic [IDX_W-1:0]  cnt_q;
    logic [N_LOC-1:0]  dir_q;
    logic              ren_q;
    logic [DATA_W-1:0] data_q;
    logic [IDX_W-1:0]  index_q;
    logic              valid_q;
    logic              busy_q;
    logic              done_q;
    logic              skip_byte;

    // One-hot decode of a location index; an out-of-range index yields all-zero.
    function automatic logic [N_LOC-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [N_LOC-1:0] v;
        v = '0;
        for (int i = 0; i < N_LOC; i++) begin
            if (idx == IDX_W'(i)) v[i] = 1'b1;
        end
        return v;
    endfunction

`ifdef SKIP_ZERO_EN
    // Zero bytes are dropped in CAPT instead of being presented.
    assign skip_byte = (ram_data_in == '0);
`else
    // Every location is presented regardless of its value.
    assign skip_byte = 1'b0;
`endif

    // Sweep controller: state, location counter and all registered outputs.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dir_q   <= '0;
            ren_q   <= 1'b0;
            data_q  <= '0;
            index_q <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            // NOTE: done defaults low every cycle so it can only ever be a
            // single-cycle pulse set on the transition into FIN.
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        cnt_q   <= '0;
                        dir_q   <= onehot('0);
                        ren_q   <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= ADDR;
                    end
                end
                ADDR: begin
                    // Address and read enable were applied on entry; RAM data
                    // becomes valid during CAPT.
                    state_q <= CAPT;
                end
                CAPT: begin
                    if (skip_byte) begin
                        if (cnt_q == LAST_IDX) begin
                            dir_q   <= '0;
                            ren_q   <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= FIN;
                        end else begin
                            cnt_q   <= cnt_q + 1'b1;
                            dir_q   <= onehot(cnt_q + 1'b1);
                            state_q <= ADDR;
                        end
                    end else begin
                        data_q  <= ram_data_in;
                        index_q <= cnt_q;
                        dir_q   <= '0;
                        ren_q   <= 1'b0;
                        valid_q <= 1'b1;
                        state_q <= PRES;
                    end
                end
                PRES: begin
                    if (out_ready) begin
                        valid_q <= 1'b0;
                        if (cnt_q == LAST_IDX) begin
                            done_q  <= 1'b1;
                            state_q <= FIN;
                        end else begin
                            cnt_q   <= cnt_q + 1'b1;
                            dir_q   <= onehot(cnt_q + 1'b1);
                            ren_q   <= 1'b1;
                            state_q <= ADDR;
                        end
                    end
                end
                FIN: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    dir_q   <= '0;
                    ren_q   <= 1'b0;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign dir_ram      = dir_q;
    assign r_ram_enable = ren_q;
    assign w_ram_enable = 1'b0;
    assign out_data     = data_q;
    assign out_index    = index_q;
    assign out_valid    = valid_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule

// File: tb/tb_fsm_lee_ram.sv
// Directed testbench for fsm_lee_ram: full sweep, stall, ignored restart,
// mid-sweep reset and (when SKIP_ZERO_EN is defined) zero-byte skipping.
module tb_fsm_lee_ram;

    localparam int N_LOC  = 32;
    localparam int DATA_W = 8;
    localparam int IDX_W  = 5;
`ifdef SKIP_ZERO_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [DATA_W-1:0] ram_data_in = '0;
    logic [N_LOC-1:0]  dir_ram;
    logic              r_ram_enable;
    logic              w_ram_enable;
    logic [DATA_W-1:0] out_data;
    logic [IDX_W-1:0]  out_index;
    logic              out_valid;
    logic              out_ready;
    logic              busy;
    logic              done;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;

    logic [DATA_W-1:0] mem [N_LOC];
    int                got_idx  [$];
    logic [DATA_W-1:0] got_data [$];

    fsm_lee_ram #(.N_LOC(N_LOC), .DATA_W(DATA_W), .IDX_W(IDX_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .ram_data_in  (ram_data_in),
        .dir_ram      (dir_ram),
        .r_ram_enable (r_ram_enable),
        .w_ram_enable (w_ram_enable),
        .out_data     (out_data),
        .out_index    (out_index),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    function automatic int decode(input logic [N_LOC-1:0] d);
        int r;
        r = 0;
        for (int i = 0; i < N_LOC; i++) if (d[i]) r = i;
        return r;
    endfunction

    // RAM model: one-cycle registered read.
    always @(posedge clk) begin
        if (r_ram_enable === 1'b1) ram_data_in <= mem[decode(dir_ram)];
    end

    // Per-cycle invariants and done-pulse counting.
    always @(negedge clk) begin
        n_checks++;
        if (w_ram_enable !== 1'b0) begin
            n_fail++;
            $display("FAIL w_ram_enable: got %b want 0 at %0t", w_ram_enable, $time);
        end
        n_checks++;
        if ($countones(dir_ram) > 1 || $isunknown(dir_ram)) begin
            n_fail++;
            $display("FAIL dir_ram_onehot: got %h at %0t", dir_ram, $time);
        end
        if (done === 1'b1) done_cnt++;
    end

    task automatic load_image();
        for (int i = 0; i < N_LOC; i++) mem[i] = 8'h00;
        mem[0]  = 8'h10;
        mem[16] = 8'h01;
        mem[17] = 8'h02;
        for (int i = 0; i < 6; i++) mem[18+i] = 8'h21 + 8'(i);
        mem[24] = 8'h41; mem[25] = 8'h42; mem[26] = 8'h43;
        mem[27] = 8'hF0; mem[28] = 8'hF1; mem[29] = 8'hF2;
        mem[30] = 8'h08;
        mem[31] = 8'h44;
    endtask

    // Cycle of the done pulse after the start-sampling edge, no stalls.
    function automatic int exp_done_cycle();
        int c;
        c = 1;
        for (int i = 0; i < N_LOC; i++) c += (SKIP && mem[i] == 8'h00) ? 2 : 3;
        return c;
    endfunction

    task automatic check_all_zero(input string tag);
        n_checks++;
        if (dir_ram !== '0 || r_ram_enable !== 1'b0 || w_ram_enable !== 1'b0 ||
            out_data !== '0 || out_index !== '0 || out_valid !== 1'b0 ||
            busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: got dir=%h ren=%b wen=%b data=%h idx=%0d vld=%b busy=%b done=%b, want all 0",
                     tag, dir_ram, r_ram_enable, w_ram_enable, out_data, out_index,
                     out_valid, busy, done);
        end
    endtask

    // Compare recorded transfers against the expected index-ordered list.
    task automatic check_transfers(input string tag);
        int exp_idx[$];
        for (int i = 0; i < N_LOC; i++) if (!(SKIP && mem[i] == 8'h00)) exp_idx.push_back(i);
        n_checks++;
        if (got_idx.size() != exp_idx.size()) begin
            n_fail++;
            $display("FAIL %s_count: got %0d transfers want %0d", tag, got_idx.size(), exp_idx.size());
        end else begin
            for (int i = 0; i < exp_idx.size(); i++) begin
                n_checks++;
                if (got_idx[i] != exp_idx[i] || got_data[i] !== mem[exp_idx[i]]) begin
                    n_fail++;
                    $display("FAIL %s_xfer%0d: got idx %0d data %h want idx %0d data %h",
                             tag, i, got_idx[i], got_data[i], exp_idx[i], mem[exp_idx[i]]);
                end
            end
        end
    endtask

    // Pulse start and follow the sweep cycle by cycle, acting as the consumer.
    task automatic run_sweep(input int stall_idx, input int stall_len, input int restart_idx,
                             input int abort_idx, output int done_cyc);
        int stall_left;
        bit restarted;
        stall_left = stall_len;
        restarted  = 1'b0;
        done_cyc   = -1;
        got_idx.delete();
        got_data.delete();
        @(posedge clk); #1;
        start     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= 400; k++) begin
            @(negedge clk);
            if (k == 1) begin
                n_checks++;
                if (busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL busy_cycle1: got %b want 1", busy);
                end
            end
            if (k == 2 || k == 3) begin
                n_checks++;
                if (out_valid !== (k == 3)) begin
                    n_fail++;
                    $display("FAIL first_valid_cycle%0d: got %b want %b", k, out_valid, k == 3);
                end
            end
            if (done === 1'b1) begin
                done_cyc = k;
                break;
            end
            if (abort_idx >= 0 && out_valid === 1'b1 && int'(out_index) == abort_idx) begin
                reset = 1'b1;
                return;
            end
            start = (restart_idx >= 0 && !restarted && out_valid === 1'b1 &&
                     int'(out_index) == restart_idx);
            if (start) restarted = 1'b1;
            if (out_valid === 1'b1 && int'(out_index) == stall_idx && stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
                n_checks++;
                if (out_data !== mem[stall_idx] || dir_ram !== '0 || r_ram_enable !== 1'b0) begin
                    n_fail++;
                    $display("FAIL stall_hold: got data %h dir %h ren %b want data %h dir 0 ren 0",
                             out_data, dir_ram, r_ram_enable, mem[stall_idx]);
                end
            end else begin
                out_ready = 1'b1;
                if (out_valid === 1'b1) begin
                    got_idx.push_back(int'(out_index));
                    got_data.push_back(out_data);
                end
            end
        end
        start     = 1'b0;
        out_ready = 1'b1;
        if (done_cyc < 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sweep_timeout: got no done within 400 cycles want done");
        end
    endtask

    task automatic check_done(input string tag, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s_done_cycle: got %0d want %0d", tag, got, want);
        end
        repeat (4) @(negedge clk);
        n_checks++;
        if (done_cnt != 1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_single_done: got %0d pulses busy %b want 1 pulse busy 0", tag, done_cnt, busy);
        end
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        start     = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("reset_state");
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("idle_after_reset");
    endtask

    task automatic test_full_sweep();
        int dc;
        done_cnt = 0;
        run_sweep(-1, 0, -1, -1, dc);
        check_done("full", dc, SKIP ? exp_done_cycle() : 97);
        check_transfers("full");
    endtask

    task automatic test_stall();
        int dc;
        done_cnt = 0;
        run_sweep(18, 5, -1, -1, dc);
        check_done("stall", dc, exp_done_cycle() + 5);
        check_transfers("stall");
    endtask

    task automatic test_restart_ignored();
        int dc;
        done_cnt = 0;
        run_sweep(-1, 0, SKIP ? 17 : 10, -1, dc);
        check_done("restart", dc, exp_done_cycle());
        check_transfers("restart");
    endtask

    task automatic test_reset_mid_sweep();
        int dc;
        done_cnt = 0;
        run_sweep(-1, 0, -1, 20, dc);
        #1;
        check_all_zero("reset_mid_immediate");
        repeat (3) @(negedge clk);
        n_checks++;
        if (done_cnt != 0) begin
            n_fail++;
            $display("FAIL reset_mid_no_done: got %0d pulses want 0", done_cnt);
        end
        reset = 1'b0;
        done_cnt = 0;
        run_sweep(-1, 0, -1, -1, dc);
        check_done("after_reset", dc, exp_done_cycle());
        check_transfers("after_reset");
    endtask

`ifdef SKIP_ZERO_EN
    task automatic test_skip_zero();
        int dc;
        done_cnt = 0;
        run_sweep(-1, 0, -1, -1, dc);
        check_done("skip", dc, 82);
        n_checks++;
        if (got_idx.size() != 17) begin
            n_fail++;
            $display("FAIL skip_count: got %0d transfers want 17", got_idx.size());
        end
        check_transfers("skip");
    endtask
`endif

    initial begin
        load_image();
        test_reset();
        test_full_sweep();
        test_stall();
        test_restart_ignored();
        test_reset_mid_sweep();
`ifdef SKIP_ZERO_EN
        test_skip_zero();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
